rle_capture_sched: RTL and testbench

- Capture sequencer for the RLE encoder path of the Logic Sniffer core. Sits between the sampler, trigger unit and command decoder on one side and the RLE encoder and sample memory write port on the other.
- Gates samples into the encoder from arm until a programmable number of post-trigger output words has been stored.
- Then forces a flush of any pending run count and signals capture complete.

---
 rtl/rle_capture_sched.sv | 158 +++++++++++++++
 tb/tb_rle_capture_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rle_capture_sched.sv
// Capture sequencer for the RLE encoder path: gates samples from arm until the
// programmed post-trigger words are stored, then flushes the pending run count.
module rle_capture_sched #(
    parameter int unsigned DELAY_W  = 16,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned FLUSH_TO = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_wr,
    input  logic               cfg_rle_en,
    input  logic [1:0]         cfg_mode,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic               sample_valid,
    input  logic               enc_valid_out,
    input  logic               enc_pending,
    output logic               enc_valid_in,
    output logic               enc_enable,
    output logic [1:0]         enc_mode,
    output logic               enc_flush,
    output logic               wr_en,
    output logic [CNT_W-1:0]   stored_count,
    output logic               running,
    output logic               triggered,
    output logic               done,
    output logic               flush_err
);

    localparam int unsigned TO_W = $clog2(FLUSH_TO + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_FLUSH,
        S_FLUSH_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic               sh_rle_en;
    logic [1:0]         sh_mode;
    logic [DELAY_W-1:0] sh_delay;
    logic [DELAY_W-1:0] delay_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               run_st;

    assign run_st       = (state == S_ARMED) || (state == S_POST) ||
                          (state == S_FLUSH) || (state == S_FLUSH_WAIT);
    assign enc_valid_in = sample_valid && ((state == S_ARMED) || (state == S_POST));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            sh_rle_en    <= 1'b0;
            sh_mode      <= '0;
            sh_delay     <= '0;
            delay_cnt    <= '0;
            to_cnt       <= '0;
            enc_enable   <= 1'b0;
            enc_mode     <= '0;
            enc_flush    <= 1'b0;
            wr_en        <= 1'b0;
            stored_count <= '0;
            running      <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            flush_err    <= 1'b0;
        end else begin
            enc_flush <= 1'b0;
            wr_en     <= 1'b0;

            if (cfg_wr && ((state == S_IDLE) || (state == S_DONE))) begin
                sh_rle_en <= cfg_rle_en;
                sh_mode   <= cfg_mode;
                sh_delay  <= cfg_delay;
            end

            // abort wins over everything, including a write on the same cycle
            if (abort) begin
                state     <= S_IDLE;
                running   <= 1'b0;
                done      <= 1'b0;
                triggered <= 1'b0;
                flush_err <= 1'b0;
            end else begin
                if (enc_valid_out && run_st) begin
                    wr_en <= 1'b1;
                    if (stored_count != '1)
                        stored_count <= stored_count + CNT_W'(1);
                end

                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            state        <= S_ARMED;
                            running      <= 1'b1;
                            done         <= 1'b0;
                            stored_count <= '0;
                            triggered    <= 1'b0;
                            flush_err    <= 1'b0;
                            enc_enable   <= sh_rle_en;
                            enc_mode     <= sh_mode;
                        end
                    end
                    S_ARMED: begin
                        if (trigger) begin
                            triggered <= 1'b1;
                            delay_cnt <= sh_delay;
                            state     <= (sh_delay == '0) ? S_FLUSH : S_POST;
                        end
                    end
                    S_POST: begin
                        if (enc_valid_out) begin
                            delay_cnt <= delay_cnt - DELAY_W'(1);
                            if (delay_cnt == DELAY_W'(1))
                                state <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        if (enc_pending) begin
                            enc_flush <= 1'b1;
                            to_cnt    <= TO_W'(FLUSH_TO);
                            state     <= S_FLUSH_WAIT;
                        end else begin
                            state   <= S_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                    S_FLUSH_WAIT: begin
                        if (enc_valid_out) begin
                            state   <= S_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (to_cnt == '0) begin
                            state     <= S_DONE;
                            running   <= 1'b0;
                            done      <= 1'b1;
                            flush_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt - TO_W'(1);
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rle_capture_sched.sv
// Directed bench for rle_capture_sched; a second instance with a narrow counter
// exercises stored_count saturation.
module tb_rle_capture_sched;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cfg_wr, cfg_rle_en;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_delay;
    logic        arm, abort, trigger, sample_valid, enc_valid_out, enc_pending;

    logic        enc_valid_in, enc_enable, enc_flush, wr_en, running, triggered, done, flush_err;
    logic [1:0]  enc_mode;
    logic [19:0] stored_count;

    logic        s_enc_valid_in, s_enc_enable, s_enc_flush, s_wr_en, s_running, s_triggered, s_done, s_flush_err;
    logic [1:0]  s_enc_mode;
    logic [3:0]  s_stored_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned lat;

    always #5 clock = ~clock;

    rle_capture_sched u_dut (
        .clock(clock), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_rle_en(cfg_rle_en),
        .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .arm(arm), .abort(abort),
        .trigger(trigger), .sample_valid(sample_valid), .enc_valid_out(enc_valid_out),
        .enc_pending(enc_pending), .enc_valid_in(enc_valid_in), .enc_enable(enc_enable),
        .enc_mode(enc_mode), .enc_flush(enc_flush), .wr_en(wr_en),
        .stored_count(stored_count), .running(running), .triggered(triggered),
        .done(done), .flush_err(flush_err)
    );

    rle_capture_sched #(.CNT_W(4)) u_sat (
        .clock(clock), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_rle_en(cfg_rle_en),
        .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .arm(arm), .abort(abort),
        .trigger(trigger), .sample_valid(sample_valid), .enc_valid_out(enc_valid_out),
        .enc_pending(enc_pending), .enc_valid_in(s_enc_valid_in), .enc_enable(s_enc_enable),
        .enc_mode(s_enc_mode), .enc_flush(s_enc_flush), .wr_en(s_wr_en),
        .stored_count(s_stored_count), .running(s_running), .triggered(s_triggered),
        .done(s_done), .flush_err(s_flush_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; cfg_wr = 1'b0; cfg_rle_en = 1'b0; cfg_mode = 2'd0; cfg_delay = 16'd0;
        arm = 1'b0; abort = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
        enc_valid_out = 1'b0; enc_pending = 1'b0;
        step(); step();
        reset_n = 1'b1;
        check("rst_running", 32'(running), 0);
        check("rst_done",    32'(done), 0);
        check("rst_count",   32'(stored_count), 0);
        check("rst_mode",    32'(enc_mode), 0);

        // Main capture: delay 8, rle on, mode 2, 5 pre-trigger words, pending flush
        cfg_wr = 1'b1; cfg_rle_en = 1'b1; cfg_mode = 2'd2; cfg_delay = 16'd8;
        step(); cfg_wr = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        check("a_running", 32'(running), 1);
        check("a_enable",  32'(enc_enable), 1);
        check("a_mode",    32'(enc_mode), 2);
        sample_valid = 1'b1; #1;
        check("a_vin_armed", 32'(enc_valid_in), 1);
        for (int i = 0; i < 5; i++) begin
            enc_valid_out = 1'b1; step();
        end
        enc_valid_out = 1'b0;
        check("a_pre_count", 32'(stored_count), 5);
        trigger = 1'b1; step(); trigger = 1'b0;
        check("a_triggered", 32'(triggered), 1);
        enc_pending = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enc_valid_out = 1'b1; step();
            check("a_post_wr", 32'(wr_en), 1);
            enc_valid_out = 1'b0;
            if (i < 7) begin
                step();
                check("a_post_gap_wr", 32'(wr_en), 0);
                check("a_post_noflush", 32'(enc_flush), 0);
                check("a_post_vin", 32'(enc_valid_in), 1);
            end
        end
        check("a_post_count", 32'(stored_count), 13);
        check("a_flush_vin",  32'(enc_valid_in), 0);
        step();
        check("a_flush_pulse", 32'(enc_flush), 1);
        step();
        check("a_flush_single", 32'(enc_flush), 0);
        enc_valid_out = 1'b1; step(); enc_valid_out = 1'b0;
        check("a_flush_wr",  32'(wr_en), 1);
        check("a_count",     32'(stored_count), 14);
        check("a_done",      32'(done), 1);
        check("a_flush_err", 32'(flush_err), 0);
        check("a_running_off", 32'(running), 0);

        // Zero delay, nothing pending: FLUSH then DONE, no flush pulse
        enc_pending = 1'b0;
        cfg_wr = 1'b1; cfg_delay = 16'd0; step(); cfg_wr = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        check("b_count_clr", 32'(stored_count), 0);
        check("b_trig_clr",  32'(triggered), 0);
        enc_valid_out = 1'b1; step(); enc_valid_out = 1'b0;
        trigger = 1'b1; step(); trigger = 1'b0;
        check("b_in_flush", 32'(running), 1);
        check("b_not_done", 32'(done), 0);
        check("b_noflush1", 32'(enc_flush), 0);
        step();
        check("b_done",     32'(done), 1);
        check("b_noflush2", 32'(enc_flush), 0);
        check("b_count",    32'(stored_count), 1);

        // Flush timeout; trigger coincident with arm is ignored
        cfg_wr = 1'b1; cfg_delay = 16'd1; step(); cfg_wr = 1'b0;
        arm = 1'b1; trigger = 1'b1; step(); arm = 1'b0; trigger = 1'b0;
        check("c_arm_trig_ignored", 32'(triggered), 0);
        check("c_running", 32'(running), 1);
        trigger = 1'b1; step(); trigger = 1'b0;
        enc_pending = 1'b1;
        enc_valid_out = 1'b1; step(); enc_valid_out = 1'b0;
        step();
        check("c_flush_pulse", 32'(enc_flush), 1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done) begin
                lat = k;
                break;
            end
        end
        check("c_timeout_lat", lat, 9);
        check("c_flush_err",   32'(flush_err), 1);
        arm = 1'b1; step(); arm = 1'b0;
        check("c_err_clr",  32'(flush_err), 0);
        check("c_trig_clr", 32'(triggered), 0);
        enc_pending = 1'b0;

        // cfg write while armed is ignored; abort beats a coincident trigger
        cfg_wr = 1'b1; cfg_mode = 2'd1; cfg_delay = 16'd3; step(); cfg_wr = 1'b0;
        trigger = 1'b1; abort = 1'b1; step(); trigger = 1'b0; abort = 1'b0;
        check("d_abort_run",  32'(running), 0);
        check("d_abort_trig", 32'(triggered), 0);
        step();
        check("d_abort_noflush", 32'(enc_flush), 0);
        arm = 1'b1; step(); arm = 1'b0;
        check("d_mode_ignored", 32'(enc_mode), 2);
        abort = 1'b1; step(); abort = 1'b0;
        cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        check("d_mode_idle", 32'(enc_mode), 1);

        // Second arm during POST is ignored and the delay keeps counting
        trigger = 1'b1; step(); trigger = 1'b0;
        enc_valid_out = 1'b1; step(); enc_valid_out = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        check("e_rearm_trig",  32'(triggered), 1);
        check("e_rearm_count", 32'(stored_count), 1);
        enc_valid_out = 1'b1; step();
        check("e_still_running", 32'(running), 1);
        step(); enc_valid_out = 1'b0;
        step();
        check("e_done",  32'(done), 1);
        check("e_count", 32'(stored_count), 3);

        // Saturation on the narrow instance
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            enc_valid_out = 1'b1; step();
        end
        enc_valid_out = 1'b0;
        check("f_sat_count",  32'(s_stored_count), 15);
        check("f_wide_count", 32'(stored_count), 20);

        // Reset mid-POST
        trigger = 1'b1; step(); trigger = 1'b0;
        sample_valid = 1'b1;
        reset_n = 1'b0; step(); reset_n = 1'b1;
        check("g_running", 32'(running), 0);
        check("g_trig",    32'(triggered), 0);
        check("g_count",   32'(stored_count), 0);
        check("g_mode",    32'(enc_mode), 0);
        check("g_enable",  32'(enc_enable), 0);
        check("g_vin",     32'(enc_valid_in), 0);
        check("g_done",    32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
